gf180mcu_osu_sc_gp9t3v3__clkdiv_prog: RTL and testbench

Programmable, glitch-free integer clock divider for the gp9t3v3 clock library. It produces a fully registered divided clock `Y` that feeds the `clkinv`/`clkbuf` cells of the clock tree directly. Ratio changes and enable/disable are applied only at period boundaries, so `Y` never carries a runt pulse except under asynchronous reset.

---
 rtl/gf180mcu_osu_sc_clk_pkg.sv | 28 ++
 rtl/gf180mcu_osu_sc_gp9t3v3__clkdiv_cnt.sv | 37 +++
 rtl/gf180mcu_osu_sc_gp9t3v3__clkdiv_prog.sv | 123 ++++++++++++
 tb/tb_gf180mcu_osu_sc_gp9t3v3__clkdiv_prog.sv | 129 ++++++++++++
 4 files changed

// File: rtl/gf180mcu_osu_sc_clk_pkg.sv
// Shared definitions for the gp9t3v3 clock-generation cells.
//   - clkdiv_state_t  : divider FSM encoding (IDLE=0, RUN=1)
//   - CLKDIV_MIN_RATIO: smallest legal division ratio
//   - clkdiv_sanitize : maps a raw ratio to a legal ratio and its high-phase length
package gf180mcu_osu_sc_clk_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } clkdiv_state_t;

    localparam int CLKDIV_MIN_RATIO = 2;

    typedef struct packed {
        logic [31:0] ratio;  // legal ratio R (>= CLKDIV_MIN_RATIO)
        logic [31:0] high;   // high-phase length H = ceil(R/2)
    } clkdiv_ratio_t;

    // Ratios 0 and 1 cannot produce a clock, so they fold up to the minimum.
    // There is no upper clamp: the largest WIDTH-bit value is itself legal.
    function automatic clkdiv_ratio_t clkdiv_sanitize(input logic [31:0] div);
        clkdiv_ratio_t res;
        res.ratio = (div < 32'(CLKDIV_MIN_RATIO)) ? 32'(CLKDIV_MIN_RATIO) : div;
        res.high  = (res.ratio + 32'd1) >> 1;
        return res;
    endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_gp9t3v3__clkdiv_cnt.sv
// Period counter for the programmable clock divider.
//   clk, rst_n : source clock, asynchronous active-low reset
//   i_load     : force the count to zero (has priority over i_inc)
//   i_inc      : advance the count by one
//   i_term     : terminal value (R-1) of the current period
//   o_cnt      : current count
//   o_tc       : high while o_cnt equals i_term
module gf180mcu_osu_sc_gp9t3v3__clkdiv_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_term,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_cnt;

    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_term);

endmodule

// File: rtl/gf180mcu_osu_sc_gp9t3v3__clkdiv_prog.sv
// Programmable glitch-free integer clock divider.
//   WIDTH : width of DIV; ratios 2 .. 2^WIDTH-1 are supported
//   CLK   : source clock
//   RN    : asynchronous active-low reset
//   EN    : run request, honoured only while idle or at a period boundary
//   DIV   : requested ratio R (0 and 1 behave as 2)
//   Y     : divided clock, straight from a flop
//   SYNC  : one-cycle pulse on the first source cycle of each divided period
// Ratio and enable are sampled only on the last cycle of a period (or while
// idle), so Y never shows a runt pulse except under asynchronous reset.
module gf180mcu_osu_sc_gp9t3v3__clkdiv_prog
    import gf180mcu_osu_sc_clk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             EN,
    input  logic [WIDTH-1:0] DIV,
    output logic             Y,
    output logic             SYNC
);

    clkdiv_state_t    r_state;
    clkdiv_state_t    w_state_nxt;
    logic [WIDTH-1:0] r_act;
    logic             r_y;
    logic             r_sync;

    logic [WIDTH-1:0] w_cnt;
    logic             w_tc;
    logic             w_cnt_load;
    logic             w_cnt_inc;
    logic             w_start;
    logic             w_y_nxt;
    logic             w_sync_nxt;
    logic [WIDTH-1:0] w_term;
    clkdiv_ratio_t    w_div_san;
    clkdiv_ratio_t    w_act_san;

    assign w_div_san = clkdiv_sanitize(32'(DIV));
    assign w_act_san = clkdiv_sanitize(32'(r_act));
    assign w_term    = w_act_san.ratio[WIDTH-1:0] - {{(WIDTH-1){1'b0}}, 1'b1};

    gf180mcu_osu_sc_gp9t3v3__clkdiv_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk    (CLK),
        .rst_n  (RN),
        .i_load (w_cnt_load),
        .i_inc  (w_cnt_inc),
        .i_term (w_term),
        .o_cnt  (w_cnt),
        .o_tc   (w_tc)
    );

    // State register.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: leave RUN only at a wrap with EN low, so the final
    // period always completes.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (EN)          w_state_nxt = ST_RUN;
            ST_RUN:  if (w_tc && !EN) w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic. An idle edge and a wrap edge behave identically: restart
    // a period if EN is high, otherwise park at zero with Y low.
    always_comb begin
        w_start    = 1'b0;
        w_cnt_load = 1'b0;
        w_cnt_inc  = 1'b0;
        w_y_nxt    = 1'b0;
        w_sync_nxt = 1'b0;
        if (r_state == ST_IDLE || w_tc) begin
            w_cnt_load = 1'b1;
            w_start    = EN;
            w_y_nxt    = EN;
            w_sync_nxt = EN;
        end else begin
            w_cnt_inc  = 1'b1;
            w_y_nxt    = ((32'(w_cnt) + 32'd1) < w_act_san.high);
        end
    end

    // Ratio shadow and output flops. A disable at a wrap leaves r_act alone;
    // it is relatched on the next restart anyway.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_act  <= WIDTH'(CLKDIV_MIN_RATIO);
            r_y    <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            if (w_start) begin
                r_act <= w_div_san.ratio[WIDTH-1:0];
            end
            r_y    <= w_y_nxt;
            r_sync <= w_sync_nxt;
        end
    end

    assign Y    = r_y;
    assign SYNC = r_sync;

    specify
        (CLK => Y)    = 0;
        (CLK => SYNC) = 0;
        (RN => Y)     = 0;
    endspecify

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__clkdiv_prog.sv
// Directed bench for the programmable clock divider. Inputs are driven and
// outputs sampled on the falling CLK edge, half a cycle from the active edge.
module tb_gf180mcu_osu_sc_gp9t3v3__clkdiv_prog;

    localparam int WIDTH = 4;

    logic             CLK;
    logic             RN;
    logic             EN;
    logic [WIDTH-1:0] DIV;
    logic             Y;
    logic             SYNC;

    int n_checks;
    int n_fail;

    gf180mcu_osu_sc_gp9t3v3__clkdiv_prog #(
        .WIDTH (WIDTH)
    ) dut (
        .CLK  (CLK),
        .RN   (RN),
        .EN   (EN),
        .DIV  (DIV),
        .Y    (Y),
        .SYNC (SYNC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Checks n cycles of a divide-by-r waveform starting at the given phase.
    // Phase p is the count after the next rising edge: Y is high for the
    // first ceil(r/2) phases, SYNC only on phase 0.
    task automatic expect_period(input string tag, input int r, input int phase0, input int n);
        for (int i = 0; i < n; i++) begin
            int p;
            p = (phase0 + i) % r;
            @(negedge CLK);
            check($sformatf("%s.y[%0d]", tag, i), {31'd0, Y}, (p < (r + 1) / 2) ? 32'd1 : 32'd0);
            check($sformatf("%s.sync[%0d]", tag, i), {31'd0, SYNC}, (p == 0) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic expect_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            check($sformatf("%s.y[%0d]", tag, i), {31'd0, Y}, 32'd0);
            check($sformatf("%s.sync[%0d]", tag, i), {31'd0, SYNC}, 32'd0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RN  = 1'b0;
        EN  = 1'b0;
        DIV = 4'd4;

        // Reset state, then one idle edge with EN low.
        @(negedge CLK);
        check("rst.y", {31'd0, Y}, 32'd0);
        check("rst.sync", {31'd0, SYNC}, 32'd0);
        RN = 1'b1;
        expect_idle("idle", 1);

        // Divide-by-4: Y 1,1,0,0. The last sample sits just before a wrap.
        EN = 1'b1;
        expect_period("div4", 4, 0, 12);

        // Odd ratio 5: high 3, low 2.
        DIV = 4'd5;
        expect_period("div5", 5, 0, 10);

        // Clamped ratios 0 and 1 behave as 2.
        DIV = 4'd0;
        expect_period("div0", 2, 0, 6);
        DIV = 4'd1;
        expect_period("div1", 2, 0, 6);

        // Mid-period change 4 -> 6 at cnt=1: this period stays 4 long.
        DIV = 4'd4;
        expect_period("chg_a", 4, 0, 2);
        DIV = 4'd6;
        expect_period("chg_b", 4, 2, 2);
        expect_period("chg_c", 6, 0, 6);

        // Two changes in one period: only the value seen at the wrap counts.
        expect_period("multi_a", 6, 0, 3);
        DIV = 4'd7;
        expect_period("multi_b", 6, 3, 3);
        DIV = 4'd4;
        expect_period("multi_c", 4, 0, 2);

        // Disable at cnt=1: the period completes, then stays idle.
        EN = 1'b0;
        expect_period("dis_tail", 4, 2, 2);
        expect_idle("dis_idle", 6);

        // Re-enable restarts on the very next edge.
        DIV = 4'd3;
        EN  = 1'b1;
        expect_period("reen", 3, 0, 7);

        // Asynchronous reset while Y and SYNC are high, between edges.
        check("pre_rst.y", {31'd0, Y}, 32'd1);
        check("pre_rst.sync", {31'd0, SYNC}, 32'd1);
        DIV = 4'd5;
        #2 RN = 1'b0;
        #1;
        check("arst.y", {31'd0, Y}, 32'd0);
        check("arst.sync", {31'd0, SYNC}, 32'd0);
        @(negedge CLK);
        check("arst_hold.y", {31'd0, Y}, 32'd0);
        RN = 1'b1;
        expect_period("restart5", 5, 0, 10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
